// File: rtl/matrix_mul_seq.sv
// Sequential NxN unsigned matrix multiplier, one result element per cycle.
// Optional accumulate mode adds the previous result onto the new product.
module matrix_mul_seq #(
    parameter int N  = 4,
    parameter int DW = 4,
    parameter int YW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              acc_mode,
    input  logic [N*N*DW-1:0] a,
    input  logic [N*N*DW-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N*N*YW-1:0] y,
    output logic              busy
);

    localparam int NE = N * N;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    generate
        if (YW < 2 * DW) begin : g_yw_chk
            $error("matrix_mul_seq: YW must be >= 2*DW");
        end
        if (N < 2) begin : g_n_chk
            $error("matrix_mul_seq: N must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t           state;
    logic [NE*DW-1:0] a_q;
    logic [NE*DW-1:0] b_q;
    logic             acc_q;
    logic [IW-1:0]    idx;
    logic [YW-1:0]    elem;

    // Dot product of row r of A with column c of B, wrapping modulo 2^YW.
    function automatic logic [YW-1:0] dot_elem(
        input logic [IW-1:0]    i,
        input logic             acc,
        input logic [YW-1:0]    prev,
        input logic [NE*DW-1:0] am,
        input logic [NE*DW-1:0] bm
    );
        int              r;
        int              c;
        logic [2*DW-1:0] p;
        logic [YW-1:0]   s;
        r = int'(i) / N;
        c = int'(i) % N;
        s = acc ? prev : '0;
        for (int k = 0; k < N; k++) begin
            p = (2*DW)'(am[(r*N+k)*DW +: DW])
              * (2*DW)'(bm[(k*N+c)*DW +: DW]);
            s = s + YW'(p);
        end
        return s;
    endfunction

    assign elem = dot_elem(idx, acc_q, y[int'(idx)*YW +: YW], a_q, b_q);

    assign in_ready = (state == IDLE) & ~rst;
    assign busy     = (state != IDLE);

    // Control FSM: capture operands, sweep elements row-major, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= 1'b0;
            idx       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc_q <= acc_mode;
                        idx   <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    y[int'(idx)*YW +: YW] <= elem;
                    if (idx == IW'(NE - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
